// File: rtl/eth_tx_frame_gen.sv
// Ethernet test-frame generator feeding a MAC TX FIFO write port with bursts of header+pattern frames.
// Optional build macro SEQ_NUM_EN: first two payload bytes carry the big-endian frames_sent count.
module eth_tx_frame_gen #(
    parameter logic [47:0] DST_MAC  = 48'h00_2B_67_B5_2E_46,
    parameter logic [47:0] SRC_MAC  = 48'h22_33_44_55_66_AA,
    parameter logic [15:0] ETH_TYPE = 16'h0000,
    parameter logic [7:0]  PAT_SEED = 8'h00,
    parameter int unsigned MIN_PAY  = 46,
    parameter int unsigned MAX_PAY  = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] payload_len,
    input  logic [15:0] frame_count,
    input  logic [7:0]  ifg_cycles,
    output logic        busy,
    output logic        done,
    output logic [15:0] frames_sent,
    output logic [31:0] ff_tx_data,
    output logic        ff_tx_sop,
    output logic        ff_tx_eop,
    output logic [1:0]  ff_tx_mod,
    output logic        ff_tx_err,
    output logic        ff_tx_wren,
    input  logic        ff_tx_rdy
);

    typedef enum logic [1:0] {IDLE, FRAME, GAP, FIN} state_e;

    state_e      state_q;
    logic [10:0] len_q;
    logic [15:0] count_q;
    logic [7:0]  ifg_q;
    logic [7:0]  gap_q;
    logic [10:0] idx_q;
    logic        stop_seen_q;

    logic [10:0] clamp_len_d;
    logic [10:0] len_sel_d;
    logic [10:0] idx_d;
    logic [31:0] data_d;
    logic        eop_d;
    logic [1:0]  mod_d;
    logic [15:0] frames_next_d;
    logic        last_frame_d;

    assign ff_tx_err = 1'b0;

    function automatic logic [15:0] typeOf(input logic [10:0] len);
        return (ETH_TYPE == 16'h0000) ? {5'b00000, len} : ETH_TYPE;
    endfunction

    function automatic logic [7:0] byteAt(input logic [12:0] p, input logic [10:0] len);
        logic [12:0]  total;
        logic [111:0] hdr;
        total = 13'd14 + {2'b00, len};
        hdr   = {DST_MAC, SRC_MAC, typeOf(len)};
        if (p < 13'd14) begin
            return hdr[7'd111 - {p[3:0], 3'b000} -: 8];
        end
        if (p >= total) begin
            return 8'h00;
        end
`ifdef SEQ_NUM_EN
        if (p == 13'd14) begin
            return frames_sent[15:8];
        end
        if (p == 13'd15) begin
            return frames_sent[7:0];
        end
`endif
        return PAT_SEED + (p[7:0] - 8'd14);
    endfunction

    function automatic logic [31:0] wordAt(input logic [10:0] idx, input logic [10:0] len);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            w = {w[23:0], byteAt({idx, 2'b00} + 13'(b), len)};
        end
        return w;
    endfunction

    function automatic logic [10:0] lastIdxOf(input logic [10:0] len);
        logic [12:0] total;
        total = 13'd14 + {2'b00, len};
        return 11'((total + 13'd3) >> 2) - 11'd1;
    endfunction

    // (14 + len) mod 4 == (len + 2) mod 4, so the empty lane count is (2 - len) mod 4
    function automatic logic [1:0] modOf(input logic [10:0] len);
        return 2'd2 - len[1:0];
    endfunction

    always_comb begin
        clamp_len_d = payload_len;
        if (payload_len < 11'(MIN_PAY)) begin
            clamp_len_d = 11'(MIN_PAY);
        end else if (payload_len > 11'(MAX_PAY)) begin
            clamp_len_d = 11'(MAX_PAY);
        end
        len_sel_d     = (state_q == IDLE) ? clamp_len_d : len_q;
        idx_d         = (state_q == FRAME && !ff_tx_eop) ? idx_q + 11'd1 : 11'd0;
        data_d        = wordAt(idx_d, len_sel_d);
        eop_d         = (idx_d == lastIdxOf(len_q));
        mod_d         = eop_d ? modOf(len_q) : 2'd0;
        frames_next_d = frames_sent + 16'd1;
        last_frame_d  = stop_seen_q || stop ||
                        ((count_q != 16'd0) && (frames_next_d == count_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            ifg_q       <= '0;
            gap_q       <= '0;
            idx_q       <= '0;
            stop_seen_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            ff_tx_data  <= '0;
            ff_tx_sop   <= 1'b0;
            ff_tx_eop   <= 1'b0;
            ff_tx_mod   <= '0;
            ff_tx_wren  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q       <= clamp_len_d;
                        count_q     <= frame_count;
                        ifg_q       <= ifg_cycles;
                        frames_sent <= '0;
                        stop_seen_q <= 1'b0;
                        idx_q       <= '0;
                        busy        <= 1'b1;
                        ff_tx_data  <= data_d;
                        ff_tx_sop   <= 1'b1;
                        ff_tx_eop   <= 1'b0;
                        ff_tx_mod   <= '0;
                        ff_tx_wren  <= 1'b1;
                        state_q     <= FRAME;
                    end
                end
                FRAME: begin
                    if (stop) begin
                        stop_seen_q <= 1'b1;
                    end
                    if (ff_tx_rdy) begin
                        if (ff_tx_eop) begin
                            frames_sent <= frames_next_d;
                            idx_q       <= '0;
                            ff_tx_eop   <= 1'b0;
                            ff_tx_mod   <= '0;
                            if (last_frame_d) begin
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                ff_tx_data <= '0;
                                ff_tx_sop  <= 1'b0;
                                ff_tx_wren <= 1'b0;
                                state_q    <= FIN;
                            end else if (ifg_q == 8'd0) begin
                                ff_tx_data <= data_d;
                                ff_tx_sop  <= 1'b1;
                            end else begin
                                gap_q      <= ifg_q;
                                ff_tx_data <= '0;
                                ff_tx_sop  <= 1'b0;
                                ff_tx_wren <= 1'b0;
                                state_q    <= GAP;
                            end
                        end else begin
                            idx_q      <= idx_d;
                            ff_tx_data <= data_d;
                            ff_tx_sop  <= 1'b0;
                            ff_tx_eop  <= eop_d;
                            ff_tx_mod  <= mod_d;
                        end
                    end
                end
                GAP: begin
                    if (stop || stop_seen_q) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= FIN;
                    end else if (gap_q == 8'd1) begin
                        ff_tx_data <= data_d;
                        ff_tx_sop  <= 1'b1;
                        ff_tx_wren <= 1'b1;
                        state_q    <= FRAME;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
